// File: rtl/fifo_rd_arbiter.sv
// Round-robin read arbiter for the 8-channel SyncFIFO read path.
// Produces a registered one-hot channel select, per-channel block flags and
// a per-grant count of accepted reads. Each grant is bounded to MAX_BURST
// reads. A one-cycle select-low gap separates any two grants.
module fifo_rd_arbiter #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req_i,
    input  logic             rd_fire_i,
    output logic [7:0]       select_o,
    output logic             grant_vld_o,
    output logic [7:0]       block_o,
    output logic [CNT_W-1:0] burst_cnt_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       last_q, last_d;
    logic [7:0]       select_q, select_d;
    logic [7:0]       block_q, block_d;
    logic             grant_vld_q, grant_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       rr_idx;
    logic             rr_found;
    logic             burst_done;
    logic             owner_req;

    // Round-robin search: first requester after the last winner, wrapping mod 8.
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rr_idx   = last_q;
        rr_found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!rr_found && req_i[3'(last_q + 3'(k))]) begin
                rr_idx   = 3'(last_q + 3'(k));
                rr_found = 1'b1;
            end
        end
    end

    // Grant-phase release conditions: owner stopped requesting, or the final
    // read of the burst is accepted this cycle.
    always_comb begin
        owner_req  = |(req_i & select_q);
        burst_done = rd_fire_i && (cnt_q == CNT_LAST);
    end

    // FSM next state, next select and burst counter.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        select_d = select_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                select_d = 8'h00;
                state_d  = ST_IDLE;
                if (rr_found) begin
                    select_d = 8'(1) << rr_idx;
                    last_d   = rr_idx;
                    cnt_d    = '0;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Reads are only counted while a grant is held; saturate at the cap.
                if (rd_fire_i && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!owner_req || burst_done) begin
                    select_d = 8'h00;
                    state_d  = ST_RELEASE;
                end
            end
            default: begin
                select_d = 8'h00;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Output views derived from the next select so they align with select_o.
    always_comb begin
        block_d     = req_i & ~select_d;
        grant_vld_d = |select_d;
    end

    // State and output registers; reset gives channel 0 first priority.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 3'd7;
            select_q    <= 8'h00;
            block_q     <= 8'h00;
            grant_vld_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            select_q    <= select_d;
            block_q     <= block_d;
            grant_vld_q <= grant_vld_d;
            cnt_q       <= cnt_d;
        end
    end

    assign select_o    = select_q;
    assign grant_vld_o = grant_vld_q;
    assign block_o     = block_q;
    assign burst_cnt_o = cnt_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter with MAX_BURST = 4.
// A cycle model predicts the outputs when each input vector is driven. The
// prediction is queued and then compared after the next rising edge. Directed
// checks pin down the key sequences with literal expected values.
module tb_fifo_rd_arbiter;

    localparam int MB = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    req = 8'h00;
    logic          rd_fire = 1'b0;
    logic [7:0]    select;
    logic          grant_vld;
    logic [7:0]    block;
    logic [CW-1:0] burst_cnt;

    fifo_rd_arbiter #(.MAX_BURST(MB), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .rd_fire_i   (rd_fire),
        .select_o    (select),
        .grant_vld_o (grant_vld),
        .block_o     (block),
        .burst_cnt_o (burst_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sel;
        logic [7:0] blk;
        logic       gv;
        logic [7:0] cnt;
    } exp_t;

    typedef enum int {M_IDLE, M_GRANT, M_REL} mst_t;

    exp_t       sb_q[$];
    mst_t       m_st;
    int         m_last;
    int         m_cnt;
    logic [7:0] m_sel;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rr_order [4] = '{8'h01, 8'h04, 8'h80, 8'h01};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st   = M_IDLE;
        m_last = 7;
        m_cnt  = 0;
        m_sel  = 8'h00;
    endtask

    // Predict the registered outputs after the coming edge and queue them.
    task automatic model_step(input logic [7:0] r, input logic f);
        logic [7:0] nsel;
        int         w;
        bit         last_read;
        exp_t       e;
        nsel = m_sel;
        case (m_st)
            M_IDLE, M_REL: begin
                nsel = 8'h00;
                m_st = M_IDLE;
                if (r != 8'h00) begin
                    w = m_last;
                    do w = (w + 1) % 8; while (!r[w]);
                    nsel   = 8'h01 << w;
                    m_last = w;
                    m_cnt  = 0;
                    m_st   = M_GRANT;
                end
            end
            M_GRANT: begin
                last_read = f && (m_cnt == MB - 1);
                if (f && m_cnt < MB) m_cnt++;
                if ((r & m_sel) == 8'h00 || last_read) begin
                    nsel = 8'h00;
                    m_st = M_REL;
                end
            end
            default: m_st = M_IDLE;
        endcase
        m_sel = nsel;
        e = '{sel: nsel, blk: r & ~nsel, gv: (nsel != 8'h00), cnt: 8'(m_cnt)};
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs, advance one edge, compare against the model.
    task automatic step(input logic [7:0] r, input logic f);
        exp_t e;
        req     = r;
        rd_fire = f;
        model_step(r, f);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sb_select", select, e.sel);
        check("sb_block", block, e.blk);
        check("sb_grant_vld", grant_vld, e.gv);
        check("sb_burst_cnt", burst_cnt, e.cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();

        // Reset held with all channels requesting: every output stays low.
        req = 8'hFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_select", select, 8'h00);
        check("rst_block", block, 8'h00);
        check("rst_grant_vld", grant_vld, 1'b0);
        check("rst_burst_cnt", burst_cnt, 0);
        rst_n = 1'b1;
        step(8'hFF, 1'b0);
        check("rst_first_select", select, 8'h01);
        check("rst_first_block", block, 8'hFE);
        check("rst_first_gv", grant_vld, 1'b1);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        // Reads with no grant are ignored.
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 1'b1);
            check("idle_cnt", burst_cnt, 0);
            check("idle_select", select, 8'h00);
        end

        // Single channel burst capped at MB reads, then one gap and a re-grant.
        step(8'h08, 1'b1);
        check("burst_grant", select, 8'h08);
        for (int i = 1; i < MB; i++) begin
            step(8'h08, 1'b1);
            check("burst_cnt", burst_cnt, i);
            check("burst_select", select, 8'h08);
        end
        step(8'h08, 1'b1);
        check("burst_gap_select", select, 8'h00);
        check("burst_final_cnt", burst_cnt, MB);
        step(8'h08, 1'b1);
        check("burst_regrant", select, 8'h08);
        check("burst_regrant_cnt", burst_cnt, 0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        // Asynchronous reset in the middle of a grant to channel 6.
        step(8'h40, 1'b0);
        step(8'h40, 1'b1);
        check("midrst_pre_cnt", burst_cnt, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_select", select, 8'h00);
        check("midrst_cnt", burst_cnt, 0);
        check("midrst_gv", grant_vld, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'h40, 1'b0);
        check("midrst_regrant", select, 8'h40);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        // Short reset pulse between edges to restart priority at channel 0.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();

        // Round-robin rotation with every grant ending on the burst cap.
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < MB + 1; c++) begin
                if (g == 3 && c == MB) break;
                step(8'h85, 1'b1);
                check("rr_select", select, (c < MB) ? rr_order[g] : 8'h00);
            end
        end
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        // Early release: channel 2 drops after two reads while channel 5 waits.
        step(8'h24, 1'b0);
        check("early_grant", select, 8'h04);
        check("early_block", block, 8'h20);
        step(8'h24, 1'b1);
        step(8'h24, 1'b1);
        check("early_cnt", burst_cnt, 2);
        step(8'h20, 1'b0);
        check("early_gap_select", select, 8'h00);
        check("early_gap_block", block, 8'h20);
        step(8'h20, 1'b0);
        check("early_next_select", select, 8'h20);
        check("early_next_block", block, 8'h00);
        check("early_next_cnt", burst_cnt, 0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
